// File: rtl/aircon_pkg.sv
// Shared definitions for the air-conditioning controller and its room model:
// plant mode encodings and the temperature range.
package aircon_pkg;

    localparam int TEMP_W = 5;

    localparam logic [TEMP_W-1:0] TEMP_MIN = 5'd0;
    localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;

    typedef enum logic [1:0] {
        MODE_DRIFT = 2'b00,
        MODE_HEAT  = 2'b01,
        MODE_COOL  = 2'b10,
        MODE_FAULT = 2'b11
    } mode_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..STEP_CYCLES-1 and pulses tick while the
// count sits on its last value.
module tick_gen #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Masked during reset so a single-cycle prescaler still reports no tick.
    assign tick = (cnt == LAST) && !rst;

endmodule

// File: rtl/room_temp_model.sv
// Thermal model of the controlled room: ramps under heating/cooling once per
// tick and drifts one degree toward ambient every LEAK_TICKS idle ticks.
module room_temp_model
    import aircon_pkg::*;
#(
    parameter logic [TEMP_W-1:0] INIT_TEMP   = 5'd20,
    parameter int                STEP_CYCLES = 4,
    parameter int                LEAK_TICKS  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              heating,
    input  logic              cooling,
    input  logic [TEMP_W-1:0] ambient,
    output logic [TEMP_W-1:0] temperature,
    output logic [1:0]        mode,
    output logic              fault,
    output logic              tick
);

    localparam int LW = (LEAK_TICKS > 1) ? $clog2(LEAK_TICKS + 1) : 1;
    localparam logic [LW-1:0] LEAK_LAST = LW'(LEAK_TICKS - 1);

    logic              tick_i;
    mode_t             mode_d;
    mode_t             mode_q;
    logic [LW-1:0]     leak_cnt;
    logic [TEMP_W-1:0] temp_q;
    logic [TEMP_W-1:0] drift_temp;
    logic              fault_q;

    tick_gen #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick_i)
    );

    always_comb begin
        mode_d = MODE_DRIFT;
        unique case ({heating, cooling})
            2'b10:   mode_d = MODE_HEAT;
            2'b01:   mode_d = MODE_COOL;
            2'b11:   mode_d = MODE_FAULT;
            default: mode_d = MODE_DRIFT;
        endcase
    end

    // Ambient lies within the temperature range, so one step toward it never wraps.
    always_comb begin
        drift_temp = temp_q;
        if (ambient > temp_q) begin
            drift_temp = temp_q + 1'b1;
        end else if (ambient < temp_q) begin
            drift_temp = temp_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_DRIFT;
            leak_cnt <= '0;
            temp_q   <= INIT_TEMP;
            fault_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            if (heating && cooling) begin
                fault_q <= 1'b1;
            end
            if (tick_i) begin
                unique case (mode_d)
                    MODE_HEAT: begin
                        if (temp_q != TEMP_MAX) begin
                            temp_q <= temp_q + 1'b1;
                        end
                        leak_cnt <= '0;
                    end
                    MODE_COOL: begin
                        if (temp_q != TEMP_MIN) begin
                            temp_q <= temp_q - 1'b1;
                        end
                        leak_cnt <= '0;
                    end
                    MODE_FAULT: begin
                        leak_cnt <= '0;
                    end
                    default: begin
                        if (leak_cnt == LEAK_LAST) begin
                            leak_cnt <= '0;
                            temp_q   <= drift_temp;
                        end else begin
                            leak_cnt <= leak_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign temperature = temp_q;
    assign mode        = mode_q;
    assign fault       = fault_q;
    assign tick        = tick_i;

endmodule

// File: tb/tb_room_temp_model.sv
// Self-checking bench for room_temp_model: a cycle model fills an expected
// queue as stimulus is driven; directed checks pin the documented scenarios.
module tb_room_temp_model;

    logic       clk;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic [4:0] ambient;
    logic [4:0] temperature;
    logic [1:0] mode;
    logic       fault;
    logic       tick;

    int tests_run = 0;
    int tests_failed = 0;

    // expected {temperature, mode, fault, tick}
    logic [8:0] exp_q[$];

    // reference model state
    int m_cnt;
    int m_leak;
    int m_temp;
    int m_mode;
    int m_fault;

    room_temp_model dut (
        .clk        (clk),
        .rst        (rst),
        .heating    (heating),
        .cooling    (cooling),
        .ambient    (ambient),
        .temperature(temperature),
        .mode       (mode),
        .fault      (fault),
        .tick       (tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge(input bit h, input bit c, input int a, input bit r);
        bit tk;
        logic [8:0] e;
        if (r) begin
            m_cnt = 0; m_leak = 0; m_temp = 20; m_mode = 0; m_fault = 0;
        end else begin
            tk = (m_cnt == 3);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (h && !c)      m_mode = 1;
            else if (c && !h) m_mode = 2;
            else if (h && c)  m_mode = 3;
            else              m_mode = 0;
            if (h && c) m_fault = 1;
            if (tk) begin
                if (h && !c) begin
                    if (m_temp < 31) m_temp = m_temp + 1;
                    m_leak = 0;
                end else if (c && !h) begin
                    if (m_temp > 0) m_temp = m_temp - 1;
                    m_leak = 0;
                end else if (h && c) begin
                    m_leak = 0;
                end else begin
                    m_leak = m_leak + 1;
                    if (m_leak == 3) begin
                        m_leak = 0;
                        if (a > m_temp)      m_temp = m_temp + 1;
                        else if (a < m_temp) m_temp = m_temp - 1;
                    end
                end
            end
        end
        e[8:4] = 5'(m_temp);
        e[3:2] = 2'(m_mode);
        e[1]   = m_fault[0];
        e[0]   = (m_cnt == 3) && !r;
        exp_q.push_back(e);
    endtask

    // driver: hold inputs across one edge, then score at the falling edge
    task automatic drive(input bit h, input bit c, input int a, input bit r);
        logic [8:0] e;
        heating = h; cooling = c; ambient = 5'(a); rst = r;
        @(posedge clk);
        model_edge(h, c, a, r);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("temp", int'(temperature), int'(e[8:4]));
            check("mode", int'(mode), int'(e[3:2]));
            check("fault", int'(fault), int'(e[1]));
            check("tick", int'(tick), int'(e[0]));
        end
    endtask

    task automatic run(input int n, input bit h, input bit c, input int a);
        for (int i = 0; i < n; i++) drive(h, c, a, 1'b0);
    endtask

    task automatic do_reset(input int a);
        drive(1'b0, 1'b0, a, 1'b1);
        drive(1'b0, 1'b0, a, 1'b1);
    endtask

    initial begin
        int t;
        bit h, c;
        int a;
        heating = 0; cooling = 0; ambient = 5'd20; rst = 1;
        m_cnt = 0; m_leak = 0; m_temp = 20; m_mode = 0; m_fault = 0;

        // reset values
        do_reset(20);
        check("rst_temp", int'(temperature), 20);
        check("rst_mode", int'(mode), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_tick", int'(tick), 0);

        // heating ramps then saturates at 31
        run(40, 1, 0, 20);
        check("heat40_temp", int'(temperature), 30);
        check("heat40_mode", int'(mode), 1);
        run(12, 1, 0, 20);
        check("heat52_temp", int'(temperature), 31);
        run(8, 1, 0, 20);
        check("heat_hold31", int'(temperature), 31);

        // cooling saturates at 0
        do_reset(20);
        run(100, 0, 1, 20);
        check("cool_temp0", int'(temperature), 0);
        check("cool_mode", int'(mode), 2);

        // fault: both commands for one cycle mid-prescale
        do_reset(20);
        run(2, 0, 0, 20);
        drive(1'b1, 1'b1, 20, 1'b0);
        check("fault_set", int'(fault), 1);
        check("fault_mode", int'(mode), 3);
        run(6, 0, 0, 20);
        check("fault_temp", int'(temperature), 20);
        check("fault_sticky", int'(fault), 1);
        do_reset(20);
        check("fault_clr", int'(fault), 0);

        // drift toward ambient 15, then toward 25
        do_reset(15);
        run(12, 0, 0, 15);
        check("drift12", int'(temperature), 19);
        run(48, 0, 0, 15);
        check("drift60", int'(temperature), 15);
        run(24, 0, 0, 15);
        check("drift_hold", int'(temperature), 15);
        run(12, 0, 0, 25);
        check("drift_up", int'(temperature), 16);

        // reset in the middle of heating; first tick 4 cycles after release
        do_reset(20);
        run(10, 1, 0, 20);
        check("pre_rst_temp", int'(temperature), 22);
        drive(1'b1, 1'b0, 20, 1'b1);
        check("mid_rst_temp", int'(temperature), 20);
        check("mid_rst_mode", int'(mode), 0);
        run(2, 0, 0, 20);
        check("post_rst_notick", int'(tick), 0);
        run(1, 0, 0, 20);
        check("post_rst_tick", int'(tick), 1);

        // closed loop with a simple bang-bang controller around setpoint 22
        do_reset(10);
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) a = $urandom_range(0, 31);
            h = (int'(temperature) < 21);
            c = (int'(temperature) > 23);
            drive(h, c, a, 1'b0);
        end
        check("loop_fault", int'(fault), 0);

        // random stimulus with occasional conflicts and resets
        for (int i = 0; i < 400; i++) begin
            t = $urandom_range(0, 99);
            h = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 2) == 0);
            drive(h, c, $urandom_range(0, 31), (t < 2));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
